// File: rtl/hyper_clk_div_pkg.sv
// hyper_clk_div_pkg
//   Shared types and helpers for the HyperBus clock divider.
//   - state_e   : divider FSM state
//   - MIN_DIV   : smallest ratio the divider will run at
//   - clamp_div : maps requested ratios 0 and 1 onto MIN_DIV
package hyper_clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopPend = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below MIN_DIV cannot produce both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/hyper_clk_div_cfg.sv
// hyper_clk_div_cfg
//   Single-entry pending register for the divide ratio, filled over a
//   valid/ready handshake and drained by an apply strobe from the core.
//   Ports:
//     clk, rst       : source clock, asynchronous active-high reset
//     cfg_valid      : requested ratio is valid
//     cfg_div        : requested ratio (clamped on capture)
//     cfg_ready      : pending slot is free; low during reset and until the
//                      first clock edge afterwards
//     apply          : core consumes the pending ratio this cycle
//     pending_valid  : a ratio is waiting to be applied
//     pending_div    : the waiting ratio
module hyper_clk_div_cfg
    import hyper_clk_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    input  logic                 apply,
    output logic                 pending_valid,
    output logic [DIV_WIDTH-1:0] pending_div
);

    logic                 ready_q;
    logic                 pend_valid_q, pend_valid_d;
    logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                 xfer;

    assign xfer = cfg_valid && ready_q;

    // Capture and apply never coincide: ready_q implies the slot is empty,
    // and apply is only raised while the slot is full.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_div_d   = pend_div_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end
        if (xfer) begin
            pend_valid_d = 1'b1;
            pend_div_d   = DIV_WIDTH'(clamp_div(32'(cfg_div)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_div_q   <= DIV_WIDTH'(MIN_DIV);
        end else begin
            ready_q      <= !pend_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_div_q   <= pend_div_d;
        end
    end

    assign cfg_ready     = ready_q;
    assign pending_valid = pend_valid_q;
    assign pending_div   = pend_div_q;

endmodule

// File: rtl/hyper_clk_div.sv
// hyper_clk_div
//   Programmable integer clock divider feeding the HyperBus 4-phase clock
//   generator. Ratio changes and start/stop only take effect on output
//   period boundaries so the downstream generator never sees a runt pulse.
//   Optional build macro: HYPER_CLK_DIV_TEST_BYPASS_EN adds test_mode_i,
//   which muxes clk_i straight onto clk_o for DFT/scan.
//   Ports:
//     clk_i        : source clock
//     rst_i        : asynchronous reset, active-high
//     clk_en_i     : run request for the divided clock
//     cfg_div_i    : requested divide ratio N
//     cfg_valid_i  : cfg_div_i valid
//     cfg_ready_o  : divider can accept a new ratio
//     clk_o        : divided clock (registered unless bypassed)
//     active_o     : divider is running or finishing its last period
//     div_o        : currently applied ratio
//     test_mode_i  : (bypass build only) clk_o = clk_i when high
//   DEFAULT_DIV must be >= 2.
module hyper_clk_div
    import hyper_clk_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_valid_i,
`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
    input  logic                 test_mode_i,
`endif
    output logic                 cfg_ready_o,
    output logic                 clk_o,
    output logic                 active_o,
    output logic [DIV_WIDTH-1:0] div_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 clk_q, clk_d;
    logic [DIV_WIDTH-1:0] half;
    logic                 running;
    logic                 wrap;
    logic                 apply;
    logic                 pending_valid;
    logic [DIV_WIDTH-1:0] pending_div;

    hyper_clk_div_cfg #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_cfg (
        .clk           (clk_i),
        .rst           (rst_i),
        .cfg_valid     (cfg_valid_i),
        .cfg_div       (cfg_div_i),
        .cfg_ready     (cfg_ready_o),
        .apply         (apply),
        .pending_valid (pending_valid),
        .pending_div   (pending_div)
    );

    assign running = (state_q != StIdle);
    assign half    = div_q >> 1;
    assign wrap    = running && (cnt_q == div_q - ONE);
    // Idle has no period in flight, so a pending ratio can go in at once.
    assign apply   = pending_valid && (!running || wrap);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clk_en_i) state_d = StRun;
            end
            StRun: begin
                if (!clk_en_i) state_d = wrap ? StIdle : StStopPend;
            end
            StStopPend: begin
                // A re-enable at the wrap keeps running without a gap.
                if (clk_en_i) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cnt_d = (!running || wrap) ? '0 : cnt_q + ONE;
        div_d = apply ? pending_div : div_q;
    end

    // Output logic; clk_d is registered so clk_o lags the counter by one cycle.
    always_comb begin
        clk_d    = running && (cnt_q < half);
        active_o = running;
        div_o    = div_q;
    end

`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
    assign clk_o = test_mode_i ? clk_i : clk_q;
`else
    assign clk_o = clk_q;
`endif

endmodule

// File: tb/tb_hyper_clk_div.sv
module tb_hyper_clk_div;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [7:0] cfg_div;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       clk_out;
    logic       active;
    logic [7:0] div;
`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
    logic       test_mode;
`endif

    int unsigned n_checks;
    int unsigned n_errors;
    logic [63:0] wave;
    logic [7:0]  div_hist [0:99];
    logic        rdy_hist [0:99];
    logic        xfer;
    int          idx;
    logic [7:0]  seq_vals [0:2];

    hyper_clk_div #(
        .DIV_WIDTH   (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_en_i    (clk_en),
        .cfg_div_i   (cfg_div),
        .cfg_valid_i (cfg_valid),
`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
        .test_mode_i (test_mode),
`endif
        .cfg_ready_o (cfg_ready),
        .clk_o       (clk_out),
        .active_o    (active),
        .div_o       (div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and shift clk_o into the wave record.
    task automatic tick();
        @(negedge clk);
        wave = {wave[62:0], clk_out};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        wave      = '0;
        rst       = 1'b1;
        clk_en    = 1'b0;
        cfg_div   = 8'd0;
        cfg_valid = 1'b0;
        seq_vals[0] = 8'd3;
        seq_vals[1] = 8'd7;
        seq_vals[2] = 8'd9;
`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
        test_mode = 1'b0;
`endif

        // Reset state, with clock edges occurring under reset
        @(negedge clk);
        @(negedge clk);
        check("rst_clk_o",  64'(clk_out),   64'd0);
        check("rst_active", 64'(active),    64'd0);
        check("rst_ready",  64'(cfg_ready), 64'd0);
        check("rst_div",    64'(div),       64'd4);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(cfg_ready), 64'd1);
        check("idle_clk_o",      64'(clk_out),   64'd0);
        check("idle_active",     64'(active),    64'd0);

        // Default ratio 4: first rise one cycle after entering RUN
        clk_en = 1'b1;
        wave = '0;
        tick();
        check("run_active", 64'(active), 64'd1);
        repeat (7) tick();
        check("wave_div4", 64'(wave[7:0]), 64'(8'b0110_0110));

        // Ratio 5 written mid-period: current period stays at 4
        tick();
        wave = '0;
        tick();
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        tick();
        cfg_valid = 1'b0;
        check("n5_ready_low", 64'(cfg_ready), 64'd0);
        check("n5_div_old",   64'(div),       64'd4);
        tick();
        tick();
        check("n5_div_new",  64'(div),          64'd5);
        check("n5_ready_hi", 64'(cfg_ready),    64'd1);
        check("n5_old_tail", 64'(wave[3:0]),    64'(4'b1100));
        wave = '0;
        repeat (10) tick();
        check("wave_div5", 64'(wave[9:0]), 64'(10'b11000_11000));

        // Ratio 0 clamps to 2
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        wave = '0;
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        check("n0_div",   64'(div),       64'd2);
        check("n0_ready", 64'(cfg_ready), 64'd1);
        repeat (4) tick();
        check("wave_div0", 64'(wave[8:0]), 64'(9'b11000_1010));

        // Ratio 1 clamps to 2
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        tick();
        cfg_valid = 1'b0;
        check("n1_ready_low", 64'(cfg_ready), 64'd0);
        tick();
        check("n1_div",      64'(div),       64'd2);
        check("n1_ready_hi", 64'(cfg_ready), 64'd1);
        wave = '0;
        repeat (4) tick();
        check("wave_div1", 64'(wave[3:0]), 64'(4'b1010));

        // Ratio 6, stop requested at counter=1: period completes, then idle
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("n6_div", 64'(div), 64'd6);
        wave = '0;
        tick();
        clk_en = 1'b0;
        tick();
        check("stop_pend_active", 64'(active), 64'd1);
        repeat (3) tick();
        check("stop_pend_active_end", 64'(active), 64'd1);
        tick();
        check("stopped_active", 64'(active), 64'd0);
        repeat (2) tick();
        check("wave_stop", 64'(wave[7:0]), 64'(8'b1110_0000));

        // Restart, drop enable briefly, re-enable before the wrap: no gap
        clk_en = 1'b1;
        wave = '0;
        tick();
        tick();
        clk_en = 1'b0;
        tick();
        clk_en = 1'b1;
        check("reenable_active", 64'(active), 64'd1);
        repeat (11) tick();
        check("wave_reenable", 64'(wave[13:0]), 64'(14'b01_1100_0111_0001));
        check("reenable_run",  64'(active),     64'd1);

        // Back-to-back ratios 3, 7, 9 with valid held high
        idx       = 0;
        cfg_valid = 1'b1;
        cfg_div   = seq_vals[0];
        for (int t = 63; t <= 77; t++) begin
            xfer = cfg_valid && cfg_ready;
            tick();
            if (xfer) begin
                idx++;
                if (idx < 3) cfg_div = seq_vals[idx];
                else         cfg_valid = 1'b0;
            end
            div_hist[t] = div;
            rdy_hist[t] = cfg_ready;
        end
        check("seq_count",   64'(idx),          64'd3);
        check("seq_div_66",  64'(div_hist[66]), 64'd6);
        check("seq_div_67",  64'(div_hist[67]), 64'd3);
        check("seq_div_69",  64'(div_hist[69]), 64'd3);
        check("seq_div_70",  64'(div_hist[70]), 64'd7);
        check("seq_div_76",  64'(div_hist[76]), 64'd7);
        check("seq_div_77",  64'(div_hist[77]), 64'd9);
        check("seq_rdy_63",  64'(rdy_hist[63]), 64'd0);
        check("seq_rdy_66",  64'(rdy_hist[66]), 64'd0);
        check("seq_rdy_67",  64'(rdy_hist[67]), 64'd1);
        check("seq_rdy_68",  64'(rdy_hist[68]), 64'd0);
        check("seq_rdy_70",  64'(rdy_hist[70]), 64'd1);
        check("seq_rdy_71",  64'(rdy_hist[71]), 64'd0);
        check("seq_rdy_76",  64'(rdy_hist[76]), 64'd0);
        check("seq_rdy_77",  64'(rdy_hist[77]), 64'd1);

        // Capture a ratio, then reset while clk_o is high
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        tick();
        cfg_valid = 1'b0;
        clk_en    = 1'b0;
        check("pre_rst_clk_high", 64'(clk_out),   64'd1);
        check("pre_rst_pending",  64'(cfg_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clk_o",  64'(clk_out), 64'd0);
        check("async_rst_div",    64'(div),     64'd4);
        check("async_rst_active", 64'(active),  64'd0);
`ifdef HYPER_CLK_DIV_TEST_BYPASS_EN
        test_mode = 1'b1;
        @(posedge clk);
        #1;
        check("bypass_high", 64'(clk_out), 64'd1);
        @(negedge clk);
        #1;
        check("bypass_low", 64'(clk_out), 64'd0);
        test_mode = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("pending_lost_ready", 64'(cfg_ready), 64'd1);
        check("pending_lost_div",   64'(div),       64'd4);
        check("post_rst_clk_o",     64'(clk_out),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hyper_clk_div.md
Name: hyper_clk_div

Overview:
- Programmable integer clock divider directly upstream of the HyperBus 4-phase clock generator; its clk_o drives that generator's input clock.
- Produces a divided, gateable clock from the SoC peripheral clock.
- Divider changes and enable/disable take effect only at output-period boundaries, so the phase generator never sees a runt pulse.
- Configuration arrives from the HyperBus register file over a valid/ready handshake.

Parameters:
- DIV_WIDTH, 8: width of the divide ratio.
- DEFAULT_DIV, 4: divide ratio loaded at reset; must be >= 2.

Ports:
- clk_i  in  1  source clock
- rst_i  in  1  asynchronous reset, active-high
- clk_en_i  in  1  run request for the divided clock
- cfg_div_i  in  DIV_WIDTH  requested divide ratio N
- cfg_valid_i  in  1  cfg_div_i valid
- cfg_ready_o  out  1  divider can accept a new ratio
- clk_o  out  1  divided clock, registered
- active_o  out  1  divider is in RUN or STOP_PEND
- div_o  out  DIV_WIDTH  currently applied ratio

Behaviour:
- Reset values (rst_i asserted, asynchronous):
  - clk_o=0, active_o=0, cfg_ready_o=0
  - div_o=DEFAULT_DIV, counter=0, pending flag=0, state IDLE
- cfg_ready_o goes 1 on the first clk_i edge after reset release.
- Ratio clamp: accepted values 0 and 1 are stored as 2. All ratios are unsigned; the counter is DIV_WIDTH bits.
- Waveform for ratio N:
  - Counter runs 0..N-1 and wraps.
  - clk_o is high for counter in [0, floor(N/2)-1] and low otherwise. Odd N therefore gives a shorter high phase.
  - clk_o is registered: 1 clk_i cycle latency from the counter.
- Handshake:
  - Transfer occurs when cfg_valid_i && cfg_ready_o; the value is captured into a pending register.
  - cfg_ready_o drops the next cycle and stays low until the pending value is applied.
  - Only one pending value is held. cfg_valid_i while ready=0 is stalled, not dropped.
- Application point:
  - In IDLE, the pending value is applied on the cycle after capture.
  - In RUN or STOP_PEND, it is applied on the cycle the counter wraps from N-1 to 0.
  - div_o updates and cfg_ready_o returns to 1 in that same cycle. The new period uses the new N.
- State machine:
  - IDLE: clk_o=0, counter held at 0. When clk_en_i=1, go to RUN; counter starts at 0 and the first rising clk_o appears 1 cycle later.
  - RUN: count. If clk_en_i=0, go to STOP_PEND.
  - STOP_PEND: finish the current period. At wrap, go to IDLE with clk_o low.
    - If clk_en_i returns to 1 before the wrap, return to RUN with no interruption of the waveform.
  - active_o=1 in RUN and STOP_PEND.
- Simultaneous events:
  - A capture in the same cycle as a wrap is applied at the next wrap, never at the current one.
  - Enable deassert and wrap in the same cycle: go straight to IDLE.
- Reset mid-period: clk_o drops to 0 asynchronously and the pending value is lost. This truncated pulse is acceptable because the phase generator shares the same reset.

Optional Feature:
- Macro: HYPER_CLK_DIV_TEST_BYPASS_EN
- When defined:
  - Adds input port test_mode_i (1 bit).
  - test_mode_i=1 makes clk_o = clk_i through a combinational mux, for DFT/scan.
  - The FSM and handshake keep running unchanged underneath.
- When undefined: no port is added and clk_o is always the registered divider output.

Decomposition:
- Package hyper_clk_div_pkg:
  - FSM state enum (IDLE, RUN, STOP_PEND)
  - constant MIN_DIV=2
  - function clamp_div
- Sub-module hyper_clk_div_cfg: pending register plus valid/ready logic. It exposes pending_valid and pending_div and takes an apply strobe from the core.

Test Plan:
- Reset, then clk_en_i=1 with DEFAULT_DIV=4 -> clk_o period 4 clk_i, 2 high / 2 low; first rise 1 cycle after RUN entry; active_o=1.
- Write N=5 mid-period -> ready low; current period keeps 4 cycles; next period 5 cycles, 2 high / 3 low; div_o=5 and ready=1 at that wrap.
- Write N=0 and N=1 -> div_o=2; clk_o toggles every cycle.
- clk_en_i=0 at counter=1 of N=6 -> period completes to 6 cycles, then IDLE with clk_o=0; re-assert before wrap -> no gap in waveform.
- cfg_valid_i held 3 back-to-back values (3, 7, 9) -> each applied at successive wraps; none lost; ready toggles accordingly.
- rst_i asserted while clk_o=1 -> clk_o=0 immediately, div_o=DEFAULT_DIV; with the bypass macro and test_mode_i=1 -> clk_o follows clk_i.
